// File: rtl/des_pkg.sv
// Shared DES constants: FIPS 46-3 permutation tables, S-boxes, FSM state type and round count.
// Table entries are 1-based DES bit numbers; DES bit n lives at vector index W-n.
package des_pkg;

  localparam int ROUNDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each S-box row packs its 16 columns as nibbles, column 0 in the top nibble.
  localparam logic [63:0] SBOX [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // Row comes from the outer bits of the 6-bit group, column from the inner four.
  function automatic logic [3:0] sbox_lookup(int box, logic [5:0] six);
    logic [63:0] row_bits;
    logic [1:0]  row;
    logic [3:0]  col;
    row      = {six[5], six[0]};
    col      = six[4:1];
    row_bits = SBOX[box][row];
    return 4'(row_bits >> (4 * (15 - int'(col))));
  endfunction

endpackage

// File: rtl/des_feistel_f.sv
// Combinational DES round function f(R,K) = P(S(E(R) ^ K)).
module des_feistel_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] e_out;
  logic [47:0] x;
  logic [31:0] s_out;

  genvar gi;

  generate
    for (gi = 0; gi < 48; gi++) begin : g_expand
      assign e_out[47-gi] = r[32-E_TAB[gi]];
    end
  endgenerate

  assign x = e_out ^ k;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_sbox
      logic [5:0] six;
      assign six                  = x[47-6*gi -: 6];
      assign s_out[31-4*gi -: 4]  = sbox_lookup(gi, six);
    end
  endgenerate

  generate
    for (gi = 0; gi < 32; gi++) begin : g_pbox
      assign f[31-gi] = s_out[32-P_TAB[gi]];
    end
  endgenerate

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES engine: IP on accept, one Feistel round per clock against the external
// round-key generator, FP into data_out on the last round edge.
module des_round_engine
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] data_out,
  output logic [4:0]  round_cnt,
  output logic [63:0] key_out,
  input  logic [47:0] round_key
);

  state_t      state_reg, state_next;
  logic [31:0] l_reg, r_reg;
  logic [31:0] f_out;
  logic        dir_reg;
  logic [4:0]  round_cnt_reg;
  logic [63:0] key_reg;
  logic [63:0] data_out_reg;
  logic [63:0] ip_data;
  logic [63:0] pre_out;
  logic [63:0] fp_data;
  logic        accept;
  logic        last_round;

  genvar gi;

  generate
    for (gi = 0; gi < 64; gi++) begin : g_perm
      assign ip_data[63-gi] = data_in[64-IP_TAB[gi]];
      assign fp_data[63-gi] = pre_out[64-FP_TAB[gi]];
    end
  endgenerate

  des_feistel_f u_feistel (
    .r (r_reg),
    .k (round_key),
    .f (f_out)
  );

  // The final round's halves go straight to FP already swapped: {R16, L16}.
  assign pre_out    = {l_reg ^ f_out, r_reg};
  assign accept     = start && (state_reg != ST_ROUND);
  assign last_round = (round_cnt_reg == (dir_reg ? 5'd1 : 5'(ROUNDS)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_ROUND;
      ST_ROUND: if (last_round) state_next = ST_DONE;
      ST_DONE:  state_next = start ? ST_ROUND : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_reg         <= '0;
      r_reg         <= '0;
      dir_reg       <= 1'b0;
      round_cnt_reg <= '0;
      key_reg       <= '0;
      data_out_reg  <= '0;
    end else if (accept) begin
      key_reg       <= key_in;
      dir_reg       <= decrypt;
      {l_reg, r_reg} <= ip_data;
      round_cnt_reg <= decrypt ? 5'(ROUNDS) : 5'd1;
    end else if (state_reg == ST_ROUND) begin
      l_reg <= r_reg;
      r_reg <= l_reg ^ f_out;
      if (last_round) begin
        round_cnt_reg <= '0;
        data_out_reg  <= fp_data;
      end else begin
        round_cnt_reg <= dir_reg ? round_cnt_reg - 5'd1 : round_cnt_reg + 5'd1;
      end
    end
  end

  assign busy      = (state_reg == ST_ROUND);
  assign done      = (state_reg == ST_DONE);
  assign data_out  = data_out_reg;
  assign round_cnt = round_cnt_reg;
  assign key_out   = key_reg;

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: a behavioural key schedule plays the round-key generator, and a
// standalone DES model checks random traffic alongside the known-answer vectors.
module tb_des_round_engine;

  logic        clk = 1'b0;
  logic        rst, start, decrypt;
  logic [63:0] data_in, key_in, data_out, key_out;
  logic        busy, done;
  logic [4:0]  round_cnt;
  logic [47:0] round_key;

  always #5 clk = ~clk;

  des_round_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .decrypt   (decrypt),
    .data_in   (data_in),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .round_cnt (round_cnt),
    .key_out   (key_out),
    .round_key (round_key)
  );

  localparam int TB_IP [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int TB_E [48] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int TB_P [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int TB_PC1 [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int TB_PC2 [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int TB_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int TB_SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [47:0] tb_subkey(logic [63:0] key, int n);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-TB_PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < n; r++)
      for (int s = 0; s < TB_SHIFT[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-TB_PC2[i]];
    return k;
  endfunction

  function automatic logic [31:0] tb_f(logic [31:0] r, logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, p;
    int six, row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-TB_E[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = int'(x[47-6*b -: 6]);
      row = (six >> 5) * 2 + (six & 1);
      col = (six >> 1) & 15;
      s[31-4*b -: 4] = 4'(TB_SB[b][row*16+col]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-TB_P[i]];
    return p;
  endfunction

  // Whole-block DES; the final permutation is taken as the inverse of IP.
  function automatic logic [63:0] tb_des(logic [63:0] key, logic [63:0] data, logic dec);
    logic [63:0] t, pre, out;
    logic [31:0] l, r, tmp;
    for (int i = 0; i < 64; i++) t[63-i] = data[64-TB_IP[i]];
    l = t[63:32];
    r = t[31:0];
    for (int rd = 1; rd <= 16; rd++) begin
      tmp = l ^ tb_f(r, tb_subkey(key, dec ? 17 - rd : rd));
      l   = r;
      r   = tmp;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) out[64-TB_IP[i]] = pre[63-i];
    return out;
  endfunction

  always_comb begin
    round_key = 48'h0;
    if (round_cnt >= 5'd1 && round_cnt <= 5'd16) round_key = tb_subkey(key_out, int'(round_cnt));
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after the cycle budget).
  task automatic run_op(input logic [63:0] key, input logic [63:0] data, input logic dec,
                        input bit scramble, input int inject_k,
                        output logic [63:0] res, output int lat, output int busy_n, output bit cnt_ok);
    int exp_cnt;
    key_in  = key;
    data_in = data;
    decrypt = dec;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    lat    = -1;
    busy_n = 0;
    cnt_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_n++;
      exp_cnt = dec ? 16 - k : k + 1;
      if (int'(round_cnt) != exp_cnt) cnt_ok = 1'b0;
      if (scramble) begin
        data_in = {$urandom, $urandom};
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom);
      end
      if (k == inject_k) begin
        start   = 1'b1;
        data_in = ~data;
        key_in  = ~key;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    res   = data_out;
  endtask

  task automatic check_op(input string name, input logic [63:0] key, input logic [63:0] res,
                          input logic [63:0] exp, input int lat, input int busy_n, input bit cnt_ok);
    check({name, " result"}, res, exp);
    check({name, " latency"}, 64'(lat), 64'd16);
    check({name, " busy cycles"}, 64'(busy_n), 64'd16);
    check({name, " round_cnt seq"}, 64'(cnt_ok), 64'd1);
    check({name, " round_cnt at done"}, 64'(round_cnt), 64'd0);
    check({name, " key_out"}, key_out, key);
  endtask

  typedef struct {
    logic [63:0] key;
    logic [63:0] data;
    logic        dec;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs [4];
  logic [63:0] res, res2, rk, rd;
  logic        rdec;
  int          lat, busy_n, extra, c0, c1;
  bit          cnt_ok;

  initial begin
    vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
    vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
    vecs[2] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
    vecs[3] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};

    rst = 1'b1; start = 1'b0; decrypt = 1'b0; data_in = '0; key_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset data_out", data_out, 64'd0);
    check("reset round_cnt", 64'(round_cnt), 64'd0);
    check("reset key_out", key_out, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].key, vecs[i].data, vecs[i].dec, 1'b0, -1, res, lat, busy_n, cnt_ok);
      check_op($sformatf("vec%0d", i), vecs[i].key, res, vecs[i].exp, lat, busy_n, cnt_ok);
      $display("vec%0d: key=%h data=%h dec=%0d out=%h latency=%0d", i, vecs[i].key, vecs[i].data,
               vecs[i].dec, res, lat);
      @(negedge clk);
      check($sformatf("vec%0d done pulse width", i), 64'(done), 64'd0);
      check($sformatf("vec%0d idle after done", i), 64'(busy), 64'd0);
    end

    // Back-to-back: decrypt issued during the DONE cycle of an encrypt.
    run_op(vecs[2].key, vecs[2].data, 1'b0, 1'b0, -1, res, lat, busy_n, cnt_ok);
    c0 = cyc;
    run_op(vecs[2].key, res, 1'b1, 1'b0, -1, res2, lat, busy_n, cnt_ok);
    c1 = cyc;
    check("b2b first result", res, 64'h0000000000000000);
    check_op("b2b second", vecs[2].key, res2, 64'h8787878787878787, lat, busy_n, cnt_ok);
    check("b2b done spacing", 64'(c1 - c0), 64'd17);
    $display("b2b: enc=%h dec=%h spacing=%0d", res, res2, c1 - c0);
    @(negedge clk);

    // start pulsed at round 5 must be dropped, not queued.
    run_op(vecs[0].key, vecs[0].data, 1'b0, 1'b0, 4, res, lat, busy_n, cnt_ok);
    check_op("ignored start", vecs[0].key, res, vecs[0].exp, lat, busy_n, cnt_ok);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignored start extra done", 64'(extra), 64'd0);
    $display("ignored start: out=%h extra_done=%0d", res, extra);

    // Reset at round 8 aborts the block.
    key_in = vecs[0].key; data_in = vecs[0].data; decrypt = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort round_cnt before rst", 64'(round_cnt), 64'd8);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort round_cnt", 64'(round_cnt), 64'd0);
    check("abort data_out", data_out, 64'd0);
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort no done", 64'(extra), 64'd0);
    $display("abort: data_out=%h stray_done=%0d", data_out, extra);
    run_op(vecs[0].key, vecs[0].data, 1'b0, 1'b0, -1, res, lat, busy_n, cnt_ok);
    check_op("after abort", vecs[0].key, res, vecs[0].exp, lat, busy_n, cnt_ok);
    $display("after abort: out=%h", res);
    @(negedge clk);

    // Inputs churn every cycle after acceptance.
    run_op(vecs[0].key, vecs[0].data, 1'b0, 1'b1, -1, res, lat, busy_n, cnt_ok);
    check("scramble result", res, vecs[0].exp);
    check("scramble latency", 64'(lat), 64'd16);
    $display("scramble: out=%h", res);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      rk   = {$urandom, $urandom};
      rd   = {$urandom, $urandom};
      rdec = 1'($urandom);
      run_op(rk, rd, rdec, 1'b0, -1, res, lat, busy_n, cnt_ok);
      check_op($sformatf("rand%0d", i), rk, res, tb_des(rk, rd, rdec), lat, busy_n, cnt_ok);
      $display("rand%0d: key=%h data=%h dec=%0d out=%h", i, rk, rd, rdec, res);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
